// File: rtl/alu_seq_core.sv
// Multi-cycle register-file/ALU core: one instruction at a time, restoring divider, load-immediate.
// Define ALU_SEQ_MUL_ITER_EN to run MUL as a WIDTH-cycle shift-add on the divider path.
module alu_seq_core #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             div_by_zero,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, WB} state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q, res_q, rem_q, quo_q;
    logic             c_q, v_q, dbz_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, is_divmod, is_nop, b_zero, iter_mul;
    logic [WIDTH:0]   sum, diff, shifted, trial, madd;
    logic [WIDTH-1:0] alu_res, wb_res;
    logic             alu_c, alu_v, wb_carry, div_ge;

    assign accept    = instr_valid && instr_ready;
    assign is_divmod = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign is_nop    = (op_q > OP_LDI);
    assign b_zero    = (b_q == '0);
    assign dbg_data  = regs[dbg_addr];

`ifdef ALU_SEQ_MUL_ITER_EN
    assign iter_mul = (op_q == OP_MUL);
`else
    assign iter_mul = 1'b0;
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Ready drops during the result_valid cycle so a new instruction never overlaps the strobe.
    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !result_valid;
                if (accept) state_n = EXEC;
            end
            EXEC: state_n = ((is_divmod && !b_zero) || iter_mul) ? DIV : WB;
            DIV:  if (cnt_q == CW'(WIDTH - 1)) state_n = WB;
            WB:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
`ifndef ALU_SEQ_MUL_ITER_EN
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                alu_c   = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            OP_DIV: alu_res = '1;
            OP_MOD: alu_res = a_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_LDI: alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    // Restoring divide step and shift-add multiply step share the rem_q/quo_q pair.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        div_ge  = !trial[WIDTH];
        madd    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    end

    always_comb begin
        wb_res   = res_q;
        wb_carry = c_q;
        if (iter_mul) begin
            wb_res   = quo_q;
            wb_carry = |rem_q;
        end else if (!dbz_q && op_q == OP_DIV) begin
            wb_res = quo_q;
        end else if (!dbz_q && op_q == OP_MOD) begin
            wb_res = rem_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because a reset must leave every register reading 0.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            c_q           <= 1'b0;
            v_q           <= 1'b0;
            dbz_q         <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q  <= instr_op;
                    rd_q  <= instr_rd;
                    imm_q <= instr_imm;
                    a_q   <= regs[instr_rs1];
                    b_q   <= regs[instr_rs2];
                end
                EXEC: begin
                    res_q <= alu_res;
                    c_q   <= alu_c;
                    v_q   <= alu_v;
                    dbz_q <= is_divmod && b_zero;
                    rem_q <= '0;
                    quo_q <= a_q;
                    cnt_q <= '0;
                end
                DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (iter_mul) begin
                        rem_q <= madd[WIDTH:1];
                        quo_q <= {madd[0], quo_q[WIDTH-1:1]};
                    end else begin
                        rem_q <= div_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], div_ge};
                    end
                end
                WB: begin
                    result_valid <= 1'b1;
                    if (!is_nop) begin
                        regs[rd_q]    <= wb_res;
                        result        <= wb_res;
                        zero_flag     <= (wb_res == '0);
                        carry_flag    <= wb_carry;
                        overflow_flag <= v_q;
                        div_by_zero   <= dbz_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8, NUM_REGS=4) with hand-computed expectations.
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2, dbg_addr;
    logic [7:0] instr_imm, result, dbg_data;
    logic       result_valid, zero_flag, carry_flag, overflow_flag, div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;
    int lat;
    bit leak;

    alu_seq_core #(.WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm),
        .result(result), .result_valid(result_valid),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .div_by_zero(div_by_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Issues one instruction and returns the number of edges from accept to the result_valid cycle.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm, input bit hold,
                             output int latency, output bit ready_leak);
        int guard = 0;
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_imm   = imm;
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        latency    = -1;
        ready_leak = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid) begin
                latency = k;
                break;
            end
            if (instr_ready) ready_leak = 1'b1;
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            tests_run++; if (dbg_data !== 8'd0) begin tests_failed++; $display("FAIL reset_reg%0d: got %0d expected 0", a, dbg_data); end
        end
        tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        tests_run++; if ({result, zero_flag, carry_flag, overflow_flag, div_by_zero} !== 12'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %0d/%b%b%b%b expected 0/0000", result, zero_flag, carry_flag, overflow_flag, div_by_zero);
        end
    endtask

    task automatic test_add();
        run_instr(4'd9, 2'd0, 2'd0, 2'd0, 8'd200, 1'b0, lat, leak);
        tests_run++; if (result !== 8'd200) begin tests_failed++; $display("FAIL ldi_r0: got %0d expected 200", result); end
        run_instr(4'd9, 2'd1, 2'd0, 2'd0, 8'd100, 1'b0, lat, leak);
        run_instr(4'd0, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, lat, leak);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL add_latency: got %0d expected 2", lat); end
        tests_run++; if (result !== 8'd44) begin tests_failed++; $display("FAIL add_result: got %0d expected 44", result); end
        tests_run++; if ({zero_flag, carry_flag, overflow_flag} !== 3'b010) begin
            tests_failed++; $display("FAIL add_flags: got z%b c%b v%b expected z0 c1 v0", zero_flag, carry_flag, overflow_flag);
        end
        dbg_addr = 2'd2;
        #1;
        tests_run++; if (dbg_data !== 8'd44) begin tests_failed++; $display("FAIL add_dbg_r2: got %0d expected 44", dbg_data); end
        tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_during_strobe: got %b expected 0", instr_ready); end
        @(negedge clk);
        tests_run++; if ({instr_ready, result_valid} !== 2'b10) begin
            tests_failed++; $display("FAIL ready_after_strobe: got ready%b valid%b expected ready1 valid0", instr_ready, result_valid);
        end
    endtask

    task automatic test_sub();
        run_instr(4'd1, 2'd3, 2'd1, 2'd0, 8'd0, 1'b0, lat, leak);
        tests_run++; if (result !== 8'd156) begin tests_failed++; $display("FAIL sub_result: got %0d expected 156", result); end
        tests_run++; if ({zero_flag, carry_flag, overflow_flag} !== 3'b011) begin
            tests_failed++; $display("FAIL sub_flags: got z%b c%b v%b expected z0 c1 v1", zero_flag, carry_flag, overflow_flag);
        end
    endtask

    task automatic test_div();
        run_instr(4'd9, 2'd1, 2'd0, 2'd0, 8'd7, 1'b0, lat, leak);
        run_instr(4'd3, 2'd2, 2'd0, 2'd1, 8'd0, 1'b1, lat, leak);
        tests_run++; if (lat !== 10) begin tests_failed++; $display("FAIL div_latency: got %0d expected 10", lat); end
        tests_run++; if (leak !== 1'b0) begin tests_failed++; $display("FAIL div_ready_busy: got %b expected 0", leak); end
        tests_run++; if (result !== 8'd28) begin tests_failed++; $display("FAIL div_result: got %0d expected 28", result); end
        @(negedge clk);
        tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("FAIL div_held_valid_ignored: got %b expected 0", result_valid); end
        run_instr(4'd4, 2'd3, 2'd0, 2'd1, 8'd0, 1'b1, lat, leak);
        tests_run++; if (lat !== 10) begin tests_failed++; $display("FAIL mod_latency: got %0d expected 10", lat); end
        tests_run++; if (result !== 8'd4) begin tests_failed++; $display("FAIL mod_result: got %0d expected 4", result); end
        tests_run++; if ({carry_flag, overflow_flag, div_by_zero} !== 3'b000) begin
            tests_failed++; $display("FAIL mod_flags: got c%b v%b dz%b expected c0 v0 dz0", carry_flag, overflow_flag, div_by_zero);
        end
    endtask

    task automatic test_div_zero();
        run_instr(4'd9, 2'd3, 2'd0, 2'd0, 8'd0, 1'b0, lat, leak);
        run_instr(4'd3, 2'd2, 2'd0, 2'd3, 8'd0, 1'b0, lat, leak);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL dbz_latency: got %0d expected 2", lat); end
        tests_run++; if (result !== 8'd255) begin tests_failed++; $display("FAIL dbz_result: got %0d expected 255", result); end
        tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
        run_instr(4'd5, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, lat, leak);
        tests_run++; if ({result, zero_flag, div_by_zero} !== {8'd0, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL and_clears_dbz: got %0d z%b dz%b expected 0 z1 dz0", result, zero_flag, div_by_zero);
        end
    endtask

    task automatic test_mul_nop();
        run_instr(4'd2, 2'd3, 2'd0, 2'd1, 8'd0, 1'b0, lat, leak);
        tests_run++; if ({result, carry_flag, overflow_flag} !== {8'd120, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL mul_result: got %0d c%b v%b expected 120 c1 v0", result, carry_flag, overflow_flag);
        end
        run_instr(4'd12, 2'd0, 2'd1, 2'd1, 8'd0, 1'b0, lat, leak);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL nop_latency: got %0d expected 2", lat); end
        tests_run++; if ({result, carry_flag} !== {8'd120, 1'b1}) begin
            tests_failed++; $display("FAIL nop_holds: got %0d c%b expected 120 c1", result, carry_flag);
        end
        dbg_addr = 2'd0;
        #1;
        tests_run++; if (dbg_data !== 8'd200) begin tests_failed++; $display("FAIL nop_no_write: got %0d expected 200", dbg_data); end
        run_instr(4'd0, 2'd0, 2'd0, 2'd0, 8'd0, 1'b0, lat, leak);
        tests_run++; if ({result, carry_flag, overflow_flag} !== {8'd144, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL add_rd_eq_rs: got %0d c%b v%b expected 144 c1 v0", result, carry_flag, overflow_flag);
        end
    endtask

    task automatic test_reset_mid();
        bit pulse = 1'b0;
        instr_valid = 1'b1;
        instr_op    = 4'd3;
        instr_rd    = 2'd2;
        instr_rs1   = 2'd0;
        instr_rs2   = 2'd1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b expected 1", instr_ready); end
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            tests_run++; if (dbg_data !== 8'd0) begin tests_failed++; $display("FAIL midrst_reg%0d: got %0d expected 0", a, dbg_data); end
        end
        repeat (2) begin
            @(negedge clk);
            if (result_valid) pulse = 1'b1;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (result_valid) pulse = 1'b1;
        end
        tests_run++; if (pulse !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_pulse: got %b expected 0", pulse); end
        run_instr(4'd0, 2'd0, 2'd0, 2'd1, 8'd0, 1'b0, lat, leak);
        tests_run++; if ({result, zero_flag, carry_flag} !== {8'd0, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL midrst_add: got %0d z%b c%b expected 0 z1 c0", result, zero_flag, carry_flag);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_imm   = '0;
        dbg_addr    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_div();
        test_div_zero();
        test_mul_nop();
        @(negedge clk);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
